// File: rtl/sram_port_arbiter.sv
// Two-port arbiter in front of the single SRAM controller: picks a requester,
// latches its command, drives the controller and returns ready/read data per port.
module sram_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int WDATA_W = 32,
  parameter int RDATA_W = 64,
  parameter int FAIR    = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req0_rd,
  input  logic               req0_wr,
  input  logic [ADDR_W-1:0]  req0_addr,
  input  logic [WDATA_W-1:0] req0_wdata,
  output logic [RDATA_W-1:0] req0_rdata,
  output logic               req0_ready,
  input  logic               req1_rd,
  input  logic               req1_wr,
  input  logic [ADDR_W-1:0]  req1_addr,
  input  logic [WDATA_W-1:0] req1_wdata,
  output logic [RDATA_W-1:0] req1_rdata,
  output logic               req1_ready,
  output logic               mem_rd_en,
  output logic               mem_wr_en,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [WDATA_W-1:0] mem_wdata,
  input  logic [RDATA_W-1:0] mem_rdata,
  input  logic               mem_ready,
  output logic [1:0]         grant
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY0 = 2'd1,
    BUSY1 = 2'd2
  } state_e;

  state_e             state_q;
  logic               last_grant_q;
  logic               rd_en_q;
  logic               wr_en_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [WDATA_W-1:0] wdata_q;
  logic [RDATA_W-1:0] rdata0_q;
  logic [RDATA_W-1:0] rdata1_q;
  logic [1:0]         grant_q;

  logic               want0;
  logic               want1;
  logic               start_d;
  logic               pick1_d;
  logic               sel_rd_d;
  logic [ADDR_W-1:0]  sel_addr_d;
  logic [WDATA_W-1:0] sel_wdata_d;

  assign want0   = req0_rd | req0_wr;
  assign want1   = req1_rd | req1_wr;
  assign start_d = want0 | want1;

  // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    pick1_d     = want1;
    sel_rd_d    = req0_rd;
    sel_addr_d  = req0_addr;
    sel_wdata_d = req0_wdata;
    if (want0 && want1) begin
      // Round-robin hands contention to the port that was not served last.
      pick1_d = (FAIR != 0) ? ~last_grant_q : 1'b0;
    end
    if (pick1_d) begin
      sel_rd_d    = req1_rd;
      sel_addr_d  = req1_addr;
      sel_wdata_d = req1_wdata;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      rd_en_q      <= 1'b0;
      wr_en_q      <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rdata0_q     <= '0;
      rdata1_q     <= '0;
      grant_q      <= 2'b00;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_d) begin
            state_q <= pick1_d ? BUSY1 : BUSY0;
            grant_q <= pick1_d ? 2'b10 : 2'b01;
            // A port asserting both rd and wr is served as a read.
            rd_en_q <= sel_rd_d;
            wr_en_q <= ~sel_rd_d;
            addr_q  <= sel_addr_d;
            wdata_q <= sel_wdata_d;
          end
        end
        BUSY0, BUSY1: begin
          if (mem_ready) begin
            state_q      <= IDLE;
            grant_q      <= 2'b00;
            rd_en_q      <= 1'b0;
            wr_en_q      <= 1'b0;
            last_grant_q <= (state_q == BUSY1);
            if (rd_en_q) begin
              if (state_q == BUSY1) rdata1_q <= mem_rdata;
              else                  rdata0_q <= mem_rdata;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req0_ready = ~want0 | ((state_q == BUSY0) & mem_ready);
  assign req1_ready = ~want1 | ((state_q == BUSY1) & mem_ready);
  assign req0_rdata = rdata0_q;
  assign req1_rdata = rdata1_q;
  assign mem_rd_en  = rd_en_q;
  assign mem_wr_en  = wr_en_q;
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign grant      = grant_q;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Bench for sram_port_arbiter: a round-robin and a fixed-priority instance, each
// with its own controller model, checked every cycle against a transaction model.
module tb_sram_port_arbiter;

  logic clk;
  logic rst;

  // Index [d][p]: d = 0 round-robin instance, d = 1 fixed-priority instance; p = port.
  logic        rd    [2][2];
  logic        wr    [2][2];
  logic [31:0] addr  [2][2];
  logic [31:0] wdata [2][2];
  logic [63:0] rdata [2][2];
  logic        rdy   [2][2];
  logic        m_rd    [2];
  logic        m_wr    [2];
  logic [31:0] m_addr  [2];
  logic [31:0] m_wdata [2];
  logic [63:0] m_rdata [2];
  logic        m_ready [2];
  logic [1:0]  gnt     [2];

  int tests  = 0;
  int failed = 0;

  bit pend  [2][2];
  int ndone [2][2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    sram_port_arbiter #(.FAIR(g == 0 ? 1 : 0)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .req0_rd   (rd[g][0]),
      .req0_wr   (wr[g][0]),
      .req0_addr (addr[g][0]),
      .req0_wdata(wdata[g][0]),
      .req0_rdata(rdata[g][0]),
      .req0_ready(rdy[g][0]),
      .req1_rd   (rd[g][1]),
      .req1_wr   (wr[g][1]),
      .req1_addr (addr[g][1]),
      .req1_wdata(wdata[g][1]),
      .req1_rdata(rdata[g][1]),
      .req1_ready(rdy[g][1]),
      .mem_rd_en (m_rd[g]),
      .mem_wr_en (m_wr[g]),
      .mem_addr  (m_addr[g]),
      .mem_wdata (m_wdata[g]),
      .mem_rdata (m_rdata[g]),
      .mem_ready (m_ready[g]),
      .grant     (gnt[g])
    );
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    tests++;
    failed++;
    $display("FAIL %s: timed out waiting for completion", name);
  endtask

  function automatic logic [63:0] fdata(input logic [31:0] a);
    if (a == 32'h0000_0040) return 64'h1122_3344_5566_7788;
    return {a ^ 32'h5A5A_A5A5, ~a};
  endfunction

  // Controller model: ready pulses on the sixth cycle an enable is held high.
  int cnt [2];
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int d = 0; d < 2; d++) begin
        cnt[d]     <= 0;
        m_ready[d] <= 1'b0;
        m_rdata[d] <= '0;
      end
    end else begin
      for (int d = 0; d < 2; d++) begin
        if ((m_rd[d] || m_wr[d]) && !m_ready[d]) begin
          if (cnt[d] == 4) begin
            m_ready[d] <= 1'b1;
            m_rdata[d] <= fdata(m_addr[d]);
            cnt[d]     <= 0;
          end else begin
            cnt[d] <= cnt[d] + 1;
          end
        end else begin
          m_ready[d] <= 1'b0;
          cnt[d]     <= 0;
        end
      end
    end
  end

  // Transaction model: who owns the controller, with what command, and what each port last read.
  int          own    [2];
  logic        last   [2];
  bit          eop_rd [2];
  logic [31:0] eaddr  [2];
  logic [31:0] ewdata [2];
  logic [63:0] erdata [2][2];

  function automatic bit wants(input int d, input int p);
    return rd[d][p] || wr[d][p];
  endfunction

  function automatic int pick(input int d);
    if (wants(d, 0) && wants(d, 1)) return (d == 0) ? 1 - int'(last[d]) : 0;
    if (wants(d, 0)) return 0;
    if (wants(d, 1)) return 1;
    return -1;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int d = 0; d < 2; d++) begin
        own[d]       <= -1;
        last[d]      <= 1'b1;
        eop_rd[d]    <= 1'b0;
        eaddr[d]     <= '0;
        ewdata[d]    <= '0;
        erdata[d][0] <= '0;
        erdata[d][1] <= '0;
      end
    end else begin
      for (int d = 0; d < 2; d++) begin
        if (own[d] < 0) begin
          if (pick(d) >= 0) begin
            own[d]    <= pick(d);
            eop_rd[d] <= rd[d][pick(d)];
            eaddr[d]  <= addr[d][pick(d)];
            ewdata[d] <= wdata[d][pick(d)];
          end
        end else if (m_ready[d]) begin
          if (eop_rd[d]) erdata[d][own[d]] <= m_rdata[d];
          last[d] <= (own[d] == 1);
          own[d]  <= -1;
        end
      end
    end
  end

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      check($sformatf("d%0d grant", d), 64'(gnt[d]),
            64'((own[d] < 0) ? 2'b00 : (own[d] == 0 ? 2'b01 : 2'b10)));
      check($sformatf("d%0d rd_en", d), 64'(m_rd[d]), 64'(own[d] >= 0 && eop_rd[d]));
      check($sformatf("d%0d wr_en", d), 64'(m_wr[d]), 64'(own[d] >= 0 && !eop_rd[d]));
      if (own[d] >= 0) begin
        check($sformatf("d%0d mem_addr", d), 64'(m_addr[d]), 64'(eaddr[d]));
        check($sformatf("d%0d mem_wdata", d), 64'(m_wdata[d]), 64'(ewdata[d]));
      end
      for (int p = 0; p < 2; p++) begin
        check($sformatf("d%0d p%0d ready", d, p), 64'(rdy[d][p]),
              64'(!wants(d, p) || (own[d] == p && m_ready[d])));
        check($sformatf("d%0d p%0d rdata", d, p), rdata[d][p], erdata[d][p]);
      end
    end
  end

  // Grant-start log used by the ordering checks.
  logic [1:0] gprev [2];
  logic [1:0] gseq0 [$];
  logic [1:0] gseq1 [$];
  always @(negedge clk) begin
    if (gnt[0] != 2'b00 && gprev[0] == 2'b00) gseq0.push_back(gnt[0]);
    if (gnt[1] != 2'b00 && gprev[1] == 2'b00) gseq1.push_back(gnt[1]);
    gprev[0] <= gnt[0];
    gprev[1] <= gnt[1];
  end

  // One cycle: note completions at the negedge, retire them just after the next posedge.
  task automatic tick();
    bit done [2][2];
    @(negedge clk);
    for (int d = 0; d < 2; d++)
      for (int p = 0; p < 2; p++)
        done[d][p] = pend[d][p] && rdy[d][p];
    @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++)
      for (int p = 0; p < 2; p++)
        if (done[d][p]) begin
          pend[d][p] = 1'b0;
          rd[d][p]   = 1'b0;
          wr[d][p]   = 1'b0;
          ndone[d][p]++;
        end
  endtask

  task automatic issue(input int d, input int p, input bit r, input bit w,
                       input logic [31:0] a, input logic [31:0] v);
    rd[d][p]    = r;
    wr[d][p]    = w;
    addr[d][p]  = a;
    wdata[d][p] = v;
    pend[d][p]  = 1'b1;
  endtask

  task automatic clear_reqs();
    for (int d = 0; d < 2; d++)
      for (int p = 0; p < 2; p++) begin
        rd[d][p]   = 1'b0;
        wr[d][p]   = 1'b0;
        pend[d][p] = 1'b0;
      end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_reqs();
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_all(input string name);
    int n = 0;
    while ((pend[0][0] || pend[0][1] || pend[1][0] || pend[1][1]) && n < 100) begin
      tick();
      n++;
    end
    if (n >= 100) begin
      timeout_fail(name);
      clear_reqs();
    end
  endtask

  initial begin
    logic [1:0] exp_seq0 [4];
    logic [1:0] exp_seq1 [4];
    int quota [2][2];
    int base  [2][2];
    int b0, b1, p1_at, n, cnt_before;

    exp_seq0 = '{2'b01, 2'b10, 2'b01, 2'b10};
    exp_seq1 = '{2'b01, 2'b01, 2'b01, 2'b01};
    rst = 1'b1;
    for (int d = 0; d < 2; d++)
      for (int p = 0; p < 2; p++) begin
        rd[d][p] = 1'b0;  wr[d][p] = 1'b0;
        addr[d][p] = '0;  wdata[d][p] = '0;
        pend[d][p] = 1'b0; ndone[d][p] = 0;
      end
    do_reset();

    // Reset values.
    for (int d = 0; d < 2; d++) begin
      check("reset grant", 64'(gnt[d]), 64'(2'b00));
      check("reset rd_en", 64'(m_rd[d]), 64'd0);
      check("reset wr_en", 64'(m_wr[d]), 64'd0);
      check("reset ready0", 64'(rdy[d][0]), 64'd1);
      check("reset ready1", 64'(rdy[d][1]), 64'd1);
      check("reset rdata0", rdata[d][0], 64'd0);
      check("reset rdata1", rdata[d][1], 64'd0);
    end

    // Single port-0 read.
    issue(0, 0, 1'b1, 1'b0, 32'h0000_0040, 32'h0);
    issue(1, 0, 1'b1, 1'b0, 32'h0000_0040, 32'h0);
    tick();
    check("p0 read grant", 64'(gnt[0]), 64'(2'b01));
    check("p0 read rd_en", 64'(m_rd[0]), 64'd1);
    wait_all("p0 read");
    check("p0 read rdata", rdata[0][0], 64'h1122_3344_5566_7788);
    check("p0 read other rdata", rdata[0][1], 64'd0);
    check("p0 read one pulse", 64'(ndone[0][0]), 64'd1);

    // Contention: round-robin alternates, fixed priority keeps port 0.
    do_reset();
    quota = '{'{2, 2}, '{4, 1}};
    for (int d = 0; d < 2; d++)
      for (int p = 0; p < 2; p++) base[d][p] = ndone[d][p];
    b0 = gseq0.size();
    b1 = gseq1.size();
    p1_at = -1;
    n = 0;
    for (int d = 0; d < 2; d++)
      for (int p = 0; p < 2; p++)
        issue(d, p, 1'b1, 1'b0, 32'h1000 + 32'(16 * (2 * d + p)), 32'h0);
    do begin
      tick();
      n++;
      if (p1_at < 0 && ndone[1][0] - base[1][0] == 4) p1_at = ndone[1][1] - base[1][1];
      for (int d = 0; d < 2; d++)
        for (int p = 0; p < 2; p++)
          if (!pend[d][p] && ndone[d][p] - base[d][p] < quota[d][p])
            issue(d, p, 1'b1, 1'b0, $urandom, 32'h0);
    end while ((pend[0][0] || pend[0][1] || pend[1][0] || pend[1][1]) && n < 300);
    if (n >= 300) begin
      timeout_fail("contention rounds");
      clear_reqs();
    end
    if (gseq0.size() >= b0 + 4 && gseq1.size() >= b1 + 4) begin
      for (int i = 0; i < 4; i++) begin
        check($sformatf("rr order %0d", i), 64'(gseq0[b0 + i]), 64'(exp_seq0[i]));
        check($sformatf("fixed order %0d", i), 64'(gseq1[b1 + i]), 64'(exp_seq1[i]));
      end
    end else begin
      timeout_fail("grant log too short");
    end
    check("fixed p1 starved", 64'(p1_at), 64'd0);

    // Port-1 write with the address changed mid-transaction.
    issue(0, 1, 1'b0, 1'b1, 32'h0000_0100, 32'hDEAD_BEEF);
    issue(1, 1, 1'b0, 1'b1, 32'h0000_0100, 32'hDEAD_BEEF);
    tick();
    tick();
    addr[0][1]  = 32'h0000_0200;  addr[1][1]  = 32'h0000_0200;
    wdata[0][1] = 32'h1234_5678;  wdata[1][1] = 32'h1234_5678;
    tick();
    check("wr held addr", 64'(m_addr[0]), 64'h100);
    check("wr held wdata", 64'(m_wdata[0]), 64'hDEAD_BEEF);
    check("wr wr_en", 64'(m_wr[0]), 64'd1);
    check("wr grant", 64'(gnt[0]), 64'(2'b10));
    wait_all("p1 write");
    check("wr wr_en after", 64'(m_wr[0]), 64'd0);

    // rd=wr=1 is a read; reset two cycles in aborts it silently.
    issue(0, 0, 1'b1, 1'b1, 32'h0000_0080, 32'h5555_AAAA);
    issue(1, 0, 1'b1, 1'b1, 32'h0000_0080, 32'h5555_AAAA);
    tick();
    check("rdwr rd_en", 64'(m_rd[0]), 64'd1);
    check("rdwr wr_en", 64'(m_wr[0]), 64'd0);
    tick();
    cnt_before = ndone[0][0];
    rst = 1'b1;
    #1;
    check("abort grant", 64'(gnt[0]), 64'(2'b00));
    check("abort rd_en", 64'(m_rd[0]), 64'd0);
    tick();
    check("abort no ready", 64'(rdy[0][0]), 64'd0);
    check("abort no completion", 64'(ndone[0][0]), 64'(cnt_before));
    clear_reqs();
    tick();
    rst = 1'b0;

    // Randomized traffic with occasional resets.
    for (int c = 0; c < 3000; c++) begin
      tick();
      if ($urandom_range(0, 399) == 0) begin
        do_reset();
      end else begin
        for (int d = 0; d < 2; d++)
          for (int p = 0; p < 2; p++) begin
            if (!pend[d][p]) begin
              if ($urandom_range(0, 3) == 0) begin
                case ($urandom_range(0, 2))
                  0:       issue(d, p, 1'b1, 1'b0, $urandom, $urandom);
                  1:       issue(d, p, 1'b0, 1'b1, $urandom, $urandom);
                  default: issue(d, p, 1'b1, 1'b1, $urandom, $urandom);
                endcase
              end
            end else if ($urandom_range(0, 7) == 0) begin
              addr[d][p]  = $urandom;
              wdata[d][p] = $urandom;
            end
          end
      end
    end
    wait_all("random drain");

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
